// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver, stepped by rising edges of a slow scan signal.
// Optional leading-zero blanking: define SEG7_LEADING_ZERO_BLANK_EN.
//
// state | meaning
// BLANK | after reset; all outputs off until the first scan tick
// SCAN  | one digit enabled, idx advances on every scan tick
module seg7_scan_driver #(
   parameter int ACTIVE_LOW   = 1,
   parameter int SNAP_ON_WRAP = 1
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic        scan_clk,
   input  logic [15:0] value,
   input  logic [3:0]  dp_mask,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   localparam logic POL = (ACTIVE_LOW != 0);

   typedef enum logic {BLANK, SCAN} state_t;

   state_t      state, state_nxt;
   logic [1:0]  idx, idx_nxt;
   logic [15:0] snap_val, snap_val_nxt;
   logic [3:0]  snap_dp, snap_dp_nxt;
   logic        scan_q, armed, tick, tick_d;
   logic        load;
   logic [3:0]  nib;
   logic        lz_blank;
   logic [3:0]  an_act;
   logic [6:0]  seg_act;
   logic        dp_act;

   function automatic logic [6:0] seg7_decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // armed blocks a tick from a scan_clk that was already high through reset
   assign tick = scan_clk & ~scan_q & armed;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state    <= BLANK;
         idx      <= 2'd0;
         snap_val <= 16'h0000;
         snap_dp  <= 4'h0;
         scan_q   <= 1'b0;
         armed    <= ~scan_clk;
         tick_d   <= 1'b0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         snap_val <= snap_val_nxt;
         snap_dp  <= snap_dp_nxt;
         scan_q   <= scan_clk;
         armed    <= armed | ~scan_clk;
         tick_d   <= tick;
      end
   end

   always_comb begin
      state_nxt    = state;
      idx_nxt      = idx;
      snap_val_nxt = snap_val;
      snap_dp_nxt  = snap_dp;
      load         = 1'b0;
      if (tick) begin
         case (state)
            BLANK: begin
               state_nxt = SCAN;
               idx_nxt   = 2'd0;
               load      = 1'b1;
            end
            default: begin
               idx_nxt = idx + 2'd1;
               load    = (SNAP_ON_WRAP == 0) || (idx == 2'd3);
            end
         endcase
      end
      if (load) begin
         snap_val_nxt = value;
         snap_dp_nxt  = dp_mask;
      end
   end

   always_comb begin
      nib = snap_val[{idx, 2'b00} +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      case (idx)
         2'd1:    lz_blank = (snap_val[15:4] == 12'h000);
         2'd2:    lz_blank = (snap_val[15:8] == 8'h00);
         2'd3:    lz_blank = (snap_val[15:12] == 4'h0);
         default: lz_blank = 1'b0;
      endcase
`else
      lz_blank = 1'b0;
`endif
      an_act  = 4'h0;
      seg_act = 7'h00;
      dp_act  = 1'b0;
      if (state == SCAN) begin
         an_act = 4'b0001 << idx;
         if (!lz_blank) begin
            seg_act = seg7_decode(nib);
            dp_act  = snap_dp[idx];
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         an         <= {4{POL}};
         seg        <= {7{POL}};
         dp         <= POL;
         frame_done <= 1'b0;
      end else begin
         an         <= an_act ^ {4{POL}};
         seg        <= seg_act ^ {7{POL}};
         dp         <= dp_act ^ POL;
         frame_done <= tick_d && (state == SCAN) && (idx == 2'd3);
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with default parameters (active-low, snapshot on wrap).
module tb_seg7_scan_driver;

   logic        clk_in = 1'b0;
   logic        rst = 1'b1;
   logic        scan_clk = 1'b0;
   logic [15:0] value = 16'h0000;
   logic [3:0]  dp_mask = 4'h0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   int vec_cnt = 0;
   int err_cnt = 0;
   int fd_cnt = 0;
   int fd_base;
   int idle_bad;

   seg7_scan_driver dut (
      .clk_in     (clk_in),
      .rst        (rst),
      .scan_clk   (scan_clk),
      .value      (value),
      .dp_mask    (dp_mask),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_done (frame_done)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) if (frame_done) fd_cnt++;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // one scan period: rise, check the selected digit, fall
   task automatic scan_step(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                            input logic e_dp);
      @(negedge clk_in) scan_clk = 1'b1;
      repeat (3) @(negedge clk_in);
      chk({tag, "_an"},  {12'h0, an}, {12'h0, e_an});
      chk({tag, "_seg"}, {9'h0, seg}, {9'h0, e_seg});
      chk({tag, "_dp"},  {15'h0, dp}, {15'h0, e_dp});
      scan_clk = 1'b0;
      repeat (3) @(negedge clk_in);
      chk({tag, "_hold_an"}, {12'h0, an}, {12'h0, e_an});
   endtask

   localparam logic [6:0] LZ_SEG =
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      7'h7F;
`else
      7'h40;
`endif

   initial begin
      repeat (3) @(negedge clk_in);
      rst = 1'b0;
      @(negedge clk_in);
      chk("rst_an",  {12'h0, an}, 16'h000F);
      chk("rst_seg", {9'h0, seg}, 16'h007F);
      chk("rst_dp",  {15'h0, dp}, 16'h0001);
      chk("rst_fd",  {15'h0, frame_done}, 16'h0000);

      idle_bad = 0;
      repeat (100) begin
         @(negedge clk_in);
         if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) idle_bad++;
      end
      chk("idle", idle_bad[15:0], 16'h0000);

      value   = 16'h12AF;
      dp_mask = 4'h0;
      fd_base = fd_cnt;
      scan_step("f0_d0", 4'b1110, 7'h0E, 1'b1);
      scan_step("f0_d1", 4'b1101, 7'h08, 1'b1);
      scan_step("f0_d2", 4'b1011, 7'h24, 1'b1);
      scan_step("f0_d3", 4'b0111, 7'h79, 1'b1);
      scan_step("f1_d0", 4'b1110, 7'h0E, 1'b1);
      chk("fd_once", 16'(fd_cnt - fd_base), 16'h0001);

      scan_step("f1_d1", 4'b1101, 7'h08, 1'b1);
      value   = 16'h0000;
      dp_mask = 4'b0010;
      scan_step("f1_d2_old", 4'b1011, 7'h24, 1'b1);
      scan_step("f1_d3_old", 4'b0111, 7'h79, 1'b1);
      scan_step("f2_d0", 4'b1110, 7'h40, 1'b1);
      scan_step("f2_d1_dp", 4'b1101, 7'h40, 1'b0);
      scan_step("f2_d2", 4'b1011, 7'h40, 1'b1);
      scan_step("f2_d3", 4'b0111, 7'h40, 1'b1);

      value   = 16'h0030;
      dp_mask = 4'h0;
      scan_step("f3_d0", 4'b1110, 7'h40, 1'b1);
      scan_step("f3_d1", 4'b1101, 7'h30, 1'b1);
      scan_step("f3_d2_lz", 4'b1011, LZ_SEG, 1'b1);
      scan_step("f3_d3_lz", 4'b0111, LZ_SEG, 1'b1);
      scan_step("f4_d0", 4'b1110, 7'h40, 1'b1);
      scan_step("f4_d1", 4'b1101, 7'h30, 1'b1);
      scan_step("f4_d2", 4'b1011, LZ_SEG, 1'b1);

      // reset coincident with a rising scan edge while digit 2 is shown
      value = 16'h5678;
      @(negedge clk_in);
      scan_clk = 1'b1;
      rst      = 1'b1;
      @(negedge clk_in);
      rst = 1'b0;
      chk("rtick_an",  {12'h0, an}, 16'h000F);
      chk("rtick_seg", {9'h0, seg}, 16'h007F);
      idle_bad = 0;
      repeat (10) begin
         @(negedge clk_in);
         if (an !== 4'hF || seg !== 7'h7F || frame_done !== 1'b0) idle_bad++;
      end
      chk("held_high", idle_bad[15:0], 16'h0000);
      scan_clk = 1'b0;
      repeat (3) @(negedge clk_in);
      chk("after_fall_an", {12'h0, an}, 16'h000F);
      scan_step("r_d0", 4'b1110, 7'h00, 1'b1);
      scan_step("r_d1", 4'b1101, 7'h78, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
